// File: rtl/mytimer_ctrl.sv
// Interval timer controller: CPU-visible config/status registers, a prescaled
// down-counter sequenced by an IDLE/LOAD/COUNT FSM, a timeout latch and a level irq.
module mytimer_ctrl #(
    parameter int unsigned CNT_W    = 25,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        irq,
    input  logic        s_cs_n,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    input  logic        s_write,
    input  logic [31:0] s_writedata
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] ADDR_CONTROL  = 2'd0;
    localparam logic [1:0] ADDR_PERIOD   = 2'd1;
    localparam logic [1:0] ADDR_STATUS   = 2'd2;
    localparam logic [1:0] ADDR_SNAPSHOT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt_c;
    logic               run;
    logic               cont;
    logic               irq_en;
    logic               to;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   counter;
    logic [PS_W-1:0]    prescaler;
    logic [31:0]        rd_mux_c;

    logic wr_ctrl_c;
    logic wr_period_c;
    logic wr_status_c;
    logic rd_en_c;
    logic tick_c;
    logic expire_c;

    // Bus decode
    always_comb begin
        wr_ctrl_c   = ~s_cs_n & s_write & (s_address == ADDR_CONTROL);
        wr_period_c = ~s_cs_n & s_write & (s_address == ADDR_PERIOD);
        wr_status_c = ~s_cs_n & s_write & (s_address == ADDR_STATUS);
        rd_en_c     = ~s_cs_n & s_read;
        tick_c      = (state == COUNT) && (prescaler == PS_W'(PRESCALE - 1));
        expire_c    = tick_c && (counter == '0);
    end

    // Next-state logic; a RUN=0 write stops the timer from any state
    always_comb begin
        state_nxt_c = state;
        case (state)
            IDLE:    if (wr_ctrl_c && s_writedata[0]) state_nxt_c = LOAD;
            LOAD:    state_nxt_c = COUNT;
            COUNT:   if (expire_c && !cont) state_nxt_c = IDLE;
            default: state_nxt_c = IDLE;
        endcase
        if (wr_ctrl_c && !s_writedata[0]) state_nxt_c = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt_c;
    end

    // Configuration registers; one-shot expiry drops RUN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run    <= 1'b0;
            cont   <= 1'b0;
            irq_en <= 1'b0;
            period <= '0;
        end else begin
            if (wr_ctrl_c) begin
                run    <= s_writedata[0];
                cont   <= s_writedata[1];
                irq_en <= s_writedata[2];
            end
            if (expire_c && !cont) run <= 1'b0;
            if (wr_period_c) period <= s_writedata[CNT_W-1:0];
        end
    end

    // Prescaler and down-counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter   <= '0;
            prescaler <= '0;
        end else begin
            case (state)
                LOAD: begin
                    counter   <= period;
                    prescaler <= '0;
                end
                COUNT: begin
                    if (tick_c) begin
                        prescaler <= '0;
                        if (counter != '0) counter <= counter - CNT_W'(1);
                        else if (cont)     counter <= period;
                    end else begin
                        prescaler <= prescaler + PS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Timeout latch (set beats clear) and registered interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (expire_c)         to <= 1'b1;
            else if (wr_status_c) to <= 1'b0;
            irq <= to & irq_en;
        end
    end

    always_comb begin
        rd_mux_c = '0;
        case (s_address)
            ADDR_CONTROL:  rd_mux_c = {29'd0, irq_en, cont, run};
            ADDR_PERIOD:   rd_mux_c = 32'(period);
            ADDR_STATUS:   rd_mux_c = {30'd0, (state == COUNT), to};
            ADDR_SNAPSHOT: rd_mux_c = 32'(counter);
            default:       rd_mux_c = '0;
        endcase
    end

    // Read data samples pre-write register values and holds between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     s_readdata <= '0;
        else if (rd_en_c) s_readdata <= rd_mux_c;
    end

endmodule

// File: tb/tb_mytimer_ctrl.sv
// Directed/randomized bench for mytimer_ctrl: two instances (PRESCALE 1 and 4) share
// one bus; expectations come from closed-form timing arithmetic on the register map.
module tb_mytimer_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs0_n, cs4_n;
    logic [1:0]  s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic        irq0, irq4;
    logic [31:0] rd0, rd4;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          t_wr, rd_cyc, t0, w, ts, p, highs, tgt;
    logic [31:0] rd_last;

    mytimer_ctrl #(.CNT_W(25), .PRESCALE(1)) u0 (
        .clk(clk), .reset_n(reset_n), .irq(irq0), .s_cs_n(cs0_n),
        .s_address(s_address), .s_read(s_read), .s_readdata(rd0),
        .s_write(s_write), .s_writedata(s_writedata)
    );

    mytimer_ctrl #(.CNT_W(25), .PRESCALE(4)) u4 (
        .clk(clk), .reset_n(reset_n), .irq(irq4), .s_cs_n(cs4_n),
        .s_address(s_address), .s_read(s_read), .s_readdata(rd4),
        .s_write(s_write), .s_writedata(s_writedata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter value after edge e for a continuous timer whose CONTROL write landed on edge t
    function automatic int cont_cnt(int e, int t, int per, int ps);
        int n;
        n = (e - t - 1) / ps;
        return per - (n % (per + 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        cs0_n = 1'b1; cs4_n = 1'b1; s_read = 1'b0; s_write = 1'b0;
        s_address = 2'd0; s_writedata = '0;
    endtask

    task automatic bus_write(input int d, input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        cs0_n = (d != 0); cs4_n = (d == 0);
        s_write = 1'b1; s_address = a; s_writedata = v;
        @(negedge clk);
        bus_idle();
        t_wr = cyc;
    endtask

    task automatic bus_read(input int d, input logic [1:0] a);
        @(negedge clk);
        cs0_n = (d != 0); cs4_n = (d == 0);
        s_read = 1'b1; s_address = a;
        rd_cyc = cyc;
        @(negedge clk);
        bus_idle();
        rd_last = (d != 0) ? rd4 : rd0;
    endtask

    task automatic wait_rise(input int d, input int budget, output int when);
        logic prev, cur;
        prev = (d != 0) ? irq4 : irq0;
        when = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cur = (d != 0) ? irq4 : irq0;
            if (cur && !prev) begin
                when = cyc;
                break;
            end
            prev = cur;
        end
        if (when < 0) chk("irq_rise_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus_idle();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_irq0", 32'(irq0), 32'd0);
        chk("rst_rd0", rd0, 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(0, 2'(a));
            chk("rst_reg", rd_last, 32'd0);
        end

        // Continuous PERIOD=9: timeout every 10 clk, cleared by STATUS write
        bus_write(0, 2'd1, 32'd9);
        bus_write(0, 2'd0, 32'd7);
        t0 = t_wr;
        wait_rise(0, 40, w);
        chk("t1_rise1", 32'(w), 32'(t0 + 12));
        bus_write(0, 2'd2, 32'd0);
        @(negedge clk);
        chk("t1_clear", 32'(irq0), 32'd0);
        wait_rise(0, 40, w);
        chk("t1_rise2", 32'(w), 32'(t0 + 22));
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            bus_read(0, 2'd3);
            chk("t1_snap", rd_last, 32'(cont_cnt(rd_cyc, t0, 9, 1)));
        end

        // Stop freezes the counter
        bus_write(0, 2'd0, 32'd0);
        ts = t_wr;
        bus_read(0, 2'd3);
        chk("stop_snap", rd_last, 32'(cont_cnt(ts, t0, 9, 1)));
        repeat (5) @(negedge clk);
        bus_read(0, 2'd3);
        chk("stop_snap_hold", rd_last, 32'(cont_cnt(ts, t0, 9, 1)));
        bus_read(0, 2'd2);
        chk("stop_running", 32'(rd_last[1]), 32'd0);

        // One-shot with random period
        bus_write(0, 2'd2, 32'd0);
        p = int'($urandom_range(0, 7));
        bus_write(0, 2'd1, 32'(p));
        bus_write(0, 2'd0, 32'd5);
        t0 = t_wr;
        wait_rise(0, 30, w);
        chk("t2_rise", 32'(w), 32'(t0 + 3 + p));
        bus_read(0, 2'd2);
        chk("t2_status", rd_last, 32'd1);
        bus_read(0, 2'd3);
        chk("t2_snap", rd_last, 32'd0);
        bus_read(0, 2'd0);
        chk("t2_control", rd_last, 32'd4);
        bus_write(0, 2'd2, 32'd0);
        @(negedge clk);
        highs = 0;
        repeat (50) begin
            @(negedge clk);
            if (irq0) highs++;
        end
        chk("t2_quiet", 32'(highs), 32'd0);
        bus_read(0, 2'd2);
        chk("t2_status_quiet", rd_last, 32'd0);

        // PRESCALE=4, PERIOD=2 continuous: timeout every 12 clk
        bus_write(1, 2'd1, 32'd2);
        bus_write(1, 2'd0, 32'd7);
        t0 = t_wr;
        wait_rise(1, 60, w);
        chk("t3_rise1", 32'(w), 32'(t0 + 14));
        bus_write(1, 2'd2, 32'd0);
        wait_rise(1, 60, w);
        chk("t3_rise2", 32'(w), 32'(t0 + 26));
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus_read(1, 2'd3);
            chk("t3_snap", rd_last, 32'(cont_cnt(rd_cyc, t0, 2, 4)));
        end
        bus_write(1, 2'd0, 32'd0);

        // PERIOD rewritten mid-count takes effect at the next reload
        bus_write(0, 2'd1, 32'd9);
        bus_write(0, 2'd0, 32'd7);
        t0 = t_wr;
        repeat (3) @(negedge clk);
        bus_write(0, 2'd1, 32'd3);
        wait_rise(0, 40, w);
        chk("t4_rise1", 32'(w), 32'(t0 + 12));
        bus_write(0, 2'd2, 32'd0);
        wait_rise(0, 40, w);
        chk("t4_rise2", 32'(w), 32'(t0 + 16));

        // STATUS write landing on a timeout edge: set wins
        tgt = t0 + 23;
        for (int i = 0; i < 40 && cyc != tgt - 1; i++) @(negedge clk);
        chk("t5_align", 32'(cyc), 32'(tgt - 1));
        cs0_n = 1'b0; s_write = 1'b1; s_address = 2'd2; s_writedata = '0;
        @(negedge clk);
        bus_idle();
        chk("t5_irq", 32'(irq0), 32'd1);
        bus_read(0, 2'd2);
        chk("t5_status", rd_last, 32'd3);
        chk("t5_irq_hold", 32'(irq0), 32'd1);

        // Asynchronous reset mid-count with irq high
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_irq_async", 32'(irq0), 32'd0);
        chk("t6_rd_async", rd0, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(0, 2'(a));
            chk("t6_reg", rd_last, 32'd0);
        end
        bus_read(1, 2'd0);
        chk("t6_reg_u4", rd_last, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
